// File: rtl/nabp_line_reader_if.sv
// Line-buffer read port and sample stream between the NABP line reader,
// its ping-pong line buffer bank and the processing-element array.
interface nabp_line_reader_if #(
    parameter int DATA_WIDTH  = 12,
    parameter int ADDR_WIDTH  = 8,
    parameter int ANGLE_WIDTH = 8
);
    logic                   mem_rd_en;
    logic                   mem_bank;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_rd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_last;
    logic [ANGLE_WIDTH-1:0] out_angle;

    modport master (
        output mem_rd_en, mem_bank, mem_addr,
        input  mem_rd_data,
        output out_valid, out_data, out_last, out_angle,
        input  out_ready
    );

    modport slave (
        input  mem_rd_en, mem_bank, mem_addr,
        output mem_rd_data,
        input  out_valid, out_data, out_last, out_angle,
        output out_ready
    );
endinterface

// File: rtl/nabp_line_reader.sv
// Reads one filtered projection line from the bank not being written and
// streams it through a 2-entry credit-managed FIFO to the PE array.
module nabp_line_reader #(
    parameter int DATA_WIDTH  = 12,
    parameter int LINE_LENGTH = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int ANGLE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   buff_sel,
    input  logic [ANGLE_WIDTH-1:0] angle,
    output logic                   busy,
    output logic                   done,
    nabp_line_reader_if.master     bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   bank_q, bank_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic                   inflight_q, inflight_d;
    logic                   rd_last_q, rd_last_d;
    logic [DATA_WIDTH-1:0]  fifo_data_q [2];
    logic [DATA_WIDTH-1:0]  fifo_data_d [2];
    logic                   fifo_last_q [2];
    logic                   fifo_last_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    logic       rd_en;
    logic       pop;
    logic       head_last;
    logic [1:0] load_after_pop;
    logic       can_issue;

    assign pop       = (count_q != 2'd0) && bus.out_ready;
    assign head_last = fifo_last_q[rd_ptr_q];
    // The slot freed by this cycle's pop is reusable: the response to a read
    // issued now is written one cycle later, so 1 sample/cycle is sustained.
    assign load_after_pop = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign can_issue      = load_after_pop < 2'd2;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        angle_d     = angle_q;
        rd_en       = 1'b0;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bank_d  = ~buff_sel;
                    angle_d = angle;
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (can_issue) begin
                    rd_en = 1'b1;
                    if (addr_q == LAST_ADDR) state_d = DRAIN;
                    else                     addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (pop && head_last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        inflight_d = rd_en;
        rd_last_d  = rd_en && (addr_q == LAST_ADDR);

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = bus.mem_rd_data;
            fifo_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bank_q      <= 1'b0;
            angle_q     <= '0;
            inflight_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '{default: 1'b0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            angle_q     <= angle_d;
            inflight_q  <= inflight_d;
            rd_last_q   <= rd_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_bank  = bank_q;
    assign bus.mem_addr  = addr_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = fifo_data_q[rd_ptr_q];
    assign bus.out_last  = head_last;
    assign bus.out_angle = angle_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_nabp_line_reader.sv
// Directed bench for nabp_line_reader: full-length lines under several
// handshake patterns, plus a LINE_LENGTH=2 instance for FIFO back-pressure.
module tb_nabp_line_reader;

    localparam int LEN = 256;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       start2;
    logic       buff_sel;
    logic [7:0] angle;
    logic       busy, done;
    logic       busy2, done2;

    int n_checks = 0;
    int n_pass   = 0;

    nabp_line_reader_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8), .ANGLE_WIDTH(8)) if_a ();
    nabp_line_reader_if #(.DATA_WIDTH(12), .ADDR_WIDTH(1), .ANGLE_WIDTH(8)) if_b ();

    nabp_line_reader #(
        .DATA_WIDTH(12), .LINE_LENGTH(LEN), .ADDR_WIDTH(8), .ANGLE_WIDTH(8)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .buff_sel(buff_sel),
        .angle(angle), .busy(busy), .done(done), .bus(if_a.master)
    );

    nabp_line_reader #(
        .DATA_WIDTH(12), .LINE_LENGTH(2), .ADDR_WIDTH(1), .ANGLE_WIDTH(8)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .buff_sel(buff_sel),
        .angle(angle), .busy(busy2), .done(done2), .bus(if_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer model: bank1[i] = i, bank0[i] = 0x800 | i, one-cycle read latency.
    always @(posedge clk) begin
        if (if_a.mem_rd_en)
            if_a.mem_rd_data <= if_a.mem_bank ? 12'(if_a.mem_addr) : (12'h800 | 12'(if_a.mem_addr));
        else
            if_a.mem_rd_data <= 12'hEEE;
        if (if_b.mem_rd_en)
            if_b.mem_rd_data <= if_b.mem_bank ? 12'(if_b.mem_addr) : (12'h800 | 12'(if_b.mem_addr));
        else
            if_b.mem_rd_data <= 12'hEEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return (k % 4 == 0) || (k % 4 == 3);
    endfunction

    task automatic run_line(input logic bsel, input logic [7:0] ang, input int mode,
                            input int extra_at, input int flip_at, input int reset_at,
                            input bit start_in_done);
        logic        exp_bank;
        logic [7:0]  exp_addr;
        logic [11:0] exp_data;
        logic        pv, pr, pl;
        logic [11:0] pd;
        int idx, first_k, last_k, done_k, reads, accepted, max_out;
        int bank_err, addr_err, stall_err, angle_err, last_err;
        bit fin, did_reset, extra_done;
        exp_bank = ~bsel; exp_addr = '0; exp_data = '0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        idx = 0; first_k = -1; last_k = -1; done_k = -1;
        reads = 0; accepted = 0; max_out = 0;
        bank_err = 0; addr_err = 0; stall_err = 0; angle_err = 0; last_err = 0;
        fin = 1'b0; did_reset = 1'b0; extra_done = 1'b0;

        @(negedge clk);
        start = 1'b1; buff_sel = bsel; angle = ang; if_a.out_ready = rdy(mode, 0);
        #1;
        check("busy_at_start", 32'(busy), 32'd0);
        check("done_at_start", 32'(done), 32'd0);

        for (int k = 1; k < 2000 && !fin; k++) begin
            @(negedge clk);
            start = start_in_done && (last_k >= 0) && (k == last_k + 1);
            if (extra_at >= 0 && idx == extra_at && !extra_done) begin
                start = 1'b1; extra_done = 1'b1;
            end
            if (flip_at >= 0 && idx == flip_at) begin
                buff_sel = ~bsel; angle = ang + 8'd9;
            end
            if_a.out_ready = rdy(mode, k);
            if (reset_at >= 0 && idx == reset_at) begin
                reset_n = 1'b0; did_reset = 1'b1; fin = 1'b1;
            end else begin
                #1;
                if (if_a.out_valid && first_k < 0) first_k = k;
                if (pv && !pr && (!if_a.out_valid || if_a.out_data !== pd || if_a.out_last !== pl))
                    stall_err++;
                if (if_a.out_valid) begin
                    exp_data = exp_bank ? 12'(idx) : (12'h800 | 12'(idx));
                    check("data", 32'(if_a.out_data), 32'(exp_data));
                    if (if_a.out_last !== (idx == LEN - 1)) last_err++;
                    if (if_a.out_angle !== ang) angle_err++;
                    if (if_a.out_ready) begin
                        accepted++;
                        if (if_a.out_last) last_k = k;
                        idx++;
                    end
                end
                if (if_a.mem_rd_en) begin
                    reads++;
                    if (if_a.mem_addr !== exp_addr) addr_err++;
                    exp_addr++;
                end
                if (busy && if_a.mem_bank !== exp_bank) bank_err++;
                if (reads - accepted > max_out) max_out = reads - accepted;
                pv = if_a.out_valid; pr = if_a.out_ready;
                pd = if_a.out_data;  pl = if_a.out_last;
                if (done) begin done_k = k; fin = 1'b1; end
            end
        end

        if (did_reset) begin
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            check("rst_busy",      32'(busy),           32'd0);
            check("rst_done",      32'(done),           32'd0);
            check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
            check("rst_mem_rd_en", 32'(if_a.mem_rd_en), 32'd0);
            check("rst_out_last",  32'(if_a.out_last),  32'd0);
            check("rst_mem_addr",  32'(if_a.mem_addr),  32'd0);
            check("rst_mem_bank",  32'(if_a.mem_bank),  32'd0);
            check("rst_out_data",  32'(if_a.out_data),  32'd0);
            check("rst_out_angle", 32'(if_a.out_angle), 32'd0);
            @(negedge clk);
            #1;
            check("rst_inflight_dropped", 32'(if_a.out_valid), 32'd0);
            check("rst_no_done",          32'(done),           32'd0);
        end else begin
            check("done_seen",       32'(done_k >= 0),    32'd1);
            check("n_samples",       32'(accepted),       32'(LEN));
            check("n_reads",         32'(reads),          32'(LEN));
            check("first_valid",     32'(first_k),        32'd3);
            check("done_after_last", 32'(done_k - last_k), 32'd1);
            check("max_outstanding", 32'(max_out),        32'd2);
            check("bank_err",        32'(bank_err),       32'd0);
            check("addr_err",        32'(addr_err),       32'd0);
            check("stall_err",       32'(stall_err),      32'd0);
            check("angle_err",       32'(angle_err),      32'd0);
            check("last_err",        32'(last_err),       32'd0);
            if (mode == 0) check("last_accept_cycle", 32'(last_k), 32'(LEN + 2));
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int reads2;
        reset_n = 1'b0; start = 1'b0; start2 = 1'b0; buff_sel = 1'b0; angle = '0;
        if_a.out_ready = 1'b1; if_b.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("init_busy",      32'(busy),           32'd0);
        check("init_out_valid", 32'(if_a.out_valid), 32'd0);
        check("init_mem_rd_en", 32'(if_a.mem_rd_en), 32'd0);
        check("init_mem_addr",  32'(if_a.mem_addr),  32'd0);
        check("init_busy2",     32'(busy2),          32'd0);
        reset_n = 1'b1;

        run_line(1'b0, 8'd37, 0, -1, -1, -1, 1'b0);
        idle_check("after_full_speed");
        run_line(1'b0, 8'd37, 1, -1, -1, -1, 1'b0);
        idle_check("after_stall");
        run_line(1'b0, 8'd40, 0, 100, 50, -1, 1'b1);
        run_line(1'b1, 8'd38, 0, -1, -1, -1, 1'b0);
        idle_check("after_back_to_back");
        run_line(1'b0, 8'd55, 0, -1, -1, 120, 1'b0);
        run_line(1'b0, 8'd56, 0, -1, -1, -1, 1'b0);
        idle_check("after_reset_line");

        // LINE_LENGTH=2 instance held off for 5 cycles after start
        @(negedge clk);
        start2 = 1'b1; buff_sel = 1'b0; angle = 8'd77; if_b.out_ready = 1'b0;
        reads2 = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            #1;
            if (if_b.mem_rd_en) reads2++;
        end
        check("l2_reads_stalled", 32'(reads2),         32'd2);
        check("l2_valid",         32'(if_b.out_valid), 32'd1);
        check("l2_hold_data",     32'(if_b.out_data),  32'd0);
        check("l2_angle",         32'(if_b.out_angle), 32'd77);
        check("l2_busy",          32'(busy2),          32'd1);
        @(negedge clk);
        if_b.out_ready = 1'b1;
        #1;
        if (if_b.mem_rd_en) reads2++;
        check("l2_s0_valid", 32'(if_b.out_valid), 32'd1);
        check("l2_s0_data",  32'(if_b.out_data),  32'd0);
        check("l2_s0_last",  32'(if_b.out_last),  32'd0);
        @(negedge clk);
        #1;
        if (if_b.mem_rd_en) reads2++;
        check("l2_s1_valid", 32'(if_b.out_valid), 32'd1);
        check("l2_s1_data",  32'(if_b.out_data),  32'd1);
        check("l2_s1_last",  32'(if_b.out_last),  32'd1);
        check("l2_s1_done",  32'(done2),          32'd0);
        @(negedge clk);
        #1;
        if (if_b.mem_rd_en) reads2++;
        check("l2_done",       32'(done2),          32'd1);
        check("l2_done_valid", 32'(if_b.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("l2_done_once", 32'(done2),  32'd0);
        check("l2_idle_busy", 32'(busy2),  32'd0);
        check("l2_reads",     32'(reads2), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nabp_line_reader.md
Name: nabp_line_reader

Overview:
Consumer-side counterpart of the NABP state control. Once per projection angle it reads one filtered projection line from the ping-pong line buffer bank that the state control is not currently writing. It streams the samples to the processing-element array over a valid/ready interface. When the line is complete it returns a one-cycle done pulse, which lets the state control advance the angle and swap buffers.

Parameters:
DATA_WIDTH, 12, bits per projection sample
LINE_LENGTH, 256, samples per projection line (≥2)
ADDR_WIDTH, 8, line buffer address width; must satisfy 2^ADDR_WIDTH ≥ LINE_LENGTH
ANGLE_WIDTH, 8, width of the angle tag

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to read one line
buff_sel  in  1  write-bank select from state control; this block reads bank ~buff_sel
angle  in  ANGLE_WIDTH  current angle, sampled with start
mem_rd_en  out  1  line buffer read strobe
mem_bank  out  1  bank being read
mem_addr  out  ADDR_WIDTH  read address
mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  sample valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  sample
out_last  out  1  marks sample LINE_LENGTH-1
out_angle  out  ANGLE_WIDTH  latched angle tag
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset (reset_n=0 at a clk edge) applies to all outputs and all internal state, including mid-line:
  - busy=0, done=0, out_valid=0, mem_rd_en=0, out_last=0.
  - mem_addr=0, mem_bank=0, out_data=0, out_angle=0.
  - FSM goes to IDLE; FIFO and all counters are cleared.
  - A read response still in flight is discarded.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 latches mem_bank <= ~buff_sel and out_angle <= angle, clears the read address and the issued count, then goes to FETCH.
  - busy rises on the next cycle.
- FETCH:
  - mem_rd_en=1 in each cycle where credits > 0, where credits = 2 − (FIFO occupancy + reads in flight).
  - mem_addr increments after each issued read.
  - After issuing read LINE_LENGTH-1, go to DRAIN; no read is ever issued beyond that address.
- Read data handling:
  - The cycle after a read is issued, mem_rd_data is written into a 2-entry FIFO.
  - The credit rule guarantees the FIFO never overflows, so no sample is lost under any out_ready pattern.
- Output stream:
  - out_valid = FIFO not empty; out_data and out_last come from the FIFO head.
  - out_last is high only for sample index LINE_LENGTH-1.
  - A sample transfers on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- Latency and throughput:
  - First out_valid appears 3 cycles after the start cycle.
  - With out_ready held at 1, throughput is 1 sample/cycle.
  - The last sample is therefore accepted LINE_LENGTH+2 cycles after start.
- DRAIN: wait until the last sample is accepted, then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - busy stays high in DONE and falls on the return to IDLE.
- Simultaneous and boundary events:
  - start while busy=1 is ignored; it is not queued.
  - start in the same cycle as done is also ignored.
  - start one cycle after done (IDLE) is accepted.
  - buff_sel or angle changing mid-line has no effect; the values latched at start are used.
  - The address counter never wraps within a line and restarts from 0 on the next start.

Test Plan:
- Reset, then start with buff_sel=0, angle=37, out_ready=1, bank1[i]=i: required response is mem_bank=1, samples 0..255 on consecutive cycles, first out_valid 3 cycles after start, out_last on data 255, out_angle=37, done 1 cycle after the last accept, busy low afterwards.
- Same as the first scenario but out_ready toggles 1,0,0,1 repeatedly: all 256 samples arrive in order with no loss or duplication, data held stable while stalled, and mem_rd_en never leaves more than 2 samples outstanding.
- Second start pulse at sample 100, plus buff_sel flipped at sample 50: the start is ignored, mem_bank stays 1 for the whole line, and done pulses exactly once.
- Back-to-back lines, with start issued the cycle after done and buff_sel=1, angle=38: the second line reads bank 0 with out_angle=38 and mem_addr restarting at 0.
- reset_n=0 for 1 cycle at sample 120 with out_ready=1: the next cycle has all outputs at reset values and no done. A subsequent start produces a full clean 256-sample line beginning at sample 0.
- LINE_LENGTH=2 with out_ready=0 for 5 cycles after start: FIFO holds samples 0 and 1 with only 2 reads issued. On release they come out as 0 then 1 with last=1, followed by a done pulse.
